// File: rtl/ic_dma_arb_pkg.sv
// Shared types and constants for the DMA read-channel arbiter.
// State encoding, default widths and line-offset width.
package ic_dma_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DW    = 128;
  localparam int AW    = 33;
  localparam int OFS_W = 4;
  localparam int CNT_W = 16;

endpackage

// File: rtl/ic_dma_rd_arb_if.sv
// Requester and DMA-side signal bundle for ic_dma_rd_arb.
// slave = arbiter side, master = requesters plus DMA model.
interface ic_dma_rd_arb_if
  import ic_dma_arb_pkg::*;
#(
  parameter int dw = DW,
  parameter int aw = AW
);

  logic [aw-1:0] r0_addr_i;
  logic          r0_valid_i;
  logic          r0_busy_o;
  logic          r0_ack_o;
  logic          r0_err_o;
  logic [aw-1:0] r0_addr_o;
  logic [dw-1:0] r0_data_o;

  logic [aw-1:0] r1_addr_i;
  logic          r1_valid_i;
  logic          r1_busy_o;
  logic          r1_ack_o;
  logic          r1_err_o;
  logic [aw-1:0] r1_addr_o;
  logic [dw-1:0] r1_data_o;

  logic [aw-1:0] dma_addr_o;
  logic          dma_valid_o;
  logic          dma_ack_i;
  logic [aw-1:0] dma_addr_i;
  logic [dw-1:0] dma_data_i;
  logic          timeout_o;
  logic          addr_err_o;

  modport slave (
    input  r0_addr_i, r0_valid_i,
    output r0_busy_o, r0_ack_o, r0_err_o,
    output r0_addr_o, r0_data_o,
    input  r1_addr_i, r1_valid_i,
    output r1_busy_o, r1_ack_o, r1_err_o,
    output r1_addr_o, r1_data_o,
    output dma_addr_o, dma_valid_o,
    input  dma_ack_i, dma_addr_i, dma_data_i,
    output timeout_o, addr_err_o
  );

  modport master (
    output r0_addr_i, r0_valid_i,
    input  r0_busy_o, r0_ack_o, r0_err_o,
    input  r0_addr_o, r0_data_o,
    output r1_addr_i, r1_valid_i,
    input  r1_busy_o, r1_ack_o, r1_err_o,
    input  r1_addr_o, r1_data_o,
    input  dma_addr_o, dma_valid_o,
    output dma_ack_i, dma_addr_i, dma_data_i,
    input  timeout_o, addr_err_o
  );

endinterface

// File: rtl/ic_dma_rd_arb_rr_arb2.sv
// Two-way round-robin pick; on a tie the requester
// that did not win last time gets the channel.
module rr_arb2 (
  input  logic [1:0] pend,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_id
);

  assign gnt_valid = |pend;

  always_comb begin
    gnt_id = 1'b0;
    unique case (1'b1)
      (pend == 2'b11): gnt_id = ~last_grant;
      (pend == 2'b10): gnt_id = 1'b1;
      default:         gnt_id = 1'b0;
    endcase
  end

endmodule

// File: rtl/ic_dma_rd_arb.sv
// Shares the DMA read channel between I$ fill (r0) and prefetch (r1).
// One transaction outstanding, address-checked acks, timeout abort.
module ic_dma_rd_arb
  import ic_dma_arb_pkg::*;
#(
  parameter int dw      = DW,
  parameter int aw      = AW,
  parameter int TIMEOUT = 255
) (
  input logic           clk,
  input logic           rst,
  ic_dma_rd_arb_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [1:0]       pend_q;
  logic [aw-1:0]    lat_addr_q [2];
  logic             last_q, gnt_q, err_q;
  logic [CNT_W-1:0] cnt_q;
  logic [aw-1:0]    dma_addr_q;
  logic             dma_valid_q, to_q, aerr_q;
  logic [aw-1:0]    rsp_addr_q [2];
  logic [dw-1:0]    rsp_data_q [2];

  logic [1:0]       valid_in, busy, cap, ack, gnt_mask;
  logic [aw-1:0]    addr_in [2];
  logic             arb_valid, arb_id;
  logic             grant, hit, miss, expire, line_eq;

  assign valid_in   = {bus.r1_valid_i, bus.r0_valid_i};
  assign addr_in[0] = bus.r0_addr_i;
  assign addr_in[1] = bus.r1_addr_i;

  always_comb begin
    busy = '0;
    ack  = '0;
    for (int i = 0; i < 2; i++) begin
      busy[i] = pend_q[i] |
                ((state_q != IDLE) && (gnt_q == 1'(i)));
      ack[i]  = (state_q == DONE) && (gnt_q == 1'(i));
    end
  end

  assign cap = valid_in & ~busy;

  rr_arb2 u_arb (
    .pend       (pend_q),
    .last_grant (last_q),
    .gnt_valid  (arb_valid),
    .gnt_id     (arb_id)
  );

  assign line_eq = bus.dma_addr_i[aw-1:OFS_W] ==
                   dma_addr_q[aw-1:OFS_W];

  // REQ with dma_valid low means the timeout already fired.
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    hit     = 1'b0;
    miss    = 1'b0;
    expire  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          grant   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (!dma_valid_q) begin
          state_d = DONE;
        end else if (bus.dma_ack_i && line_eq) begin
          hit     = 1'b1;
          state_d = DONE;
        end else begin
          miss   = bus.dma_ack_i;
          expire = (cnt_q == CNT_MAX);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign gnt_mask = grant ? (2'b01 << arb_id) : 2'b00;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q      <= '0;
      last_q      <= 1'b1;
      gnt_q       <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      dma_addr_q  <= '0;
      dma_valid_q <= 1'b0;
      to_q        <= 1'b0;
      aerr_q      <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        lat_addr_q[i] <= '0;
        rsp_addr_q[i] <= '0;
        rsp_data_q[i] <= '0;
      end
    end else begin
      to_q   <= expire;
      aerr_q <= miss;
      pend_q <= (pend_q | cap) & ~gnt_mask;
      for (int i = 0; i < 2; i++)
        if (cap[i]) lat_addr_q[i] <= addr_in[i];
      if (grant) begin
        gnt_q       <= arb_id;
        last_q      <= arb_id;
        dma_addr_q  <= lat_addr_q[arb_id];
        dma_valid_q <= 1'b1;
        cnt_q       <= '0;
      end
      if (state_q == REQ && dma_valid_q)
        cnt_q <= cnt_q + CNT_W'(1);
      if (hit) begin
        dma_valid_q       <= 1'b0;
        err_q             <= 1'b0;
        rsp_data_q[gnt_q] <= bus.dma_data_i;
        rsp_addr_q[gnt_q] <= bus.dma_addr_i;
      end
      if (expire) begin
        dma_valid_q       <= 1'b0;
        err_q             <= 1'b1;
        rsp_data_q[gnt_q] <= '0;
        rsp_addr_q[gnt_q] <= dma_addr_q;
      end
    end
  end

  assign bus.r0_busy_o   = busy[0];
  assign bus.r0_ack_o    = ack[0];
  assign bus.r0_err_o    = ack[0] & err_q;
  assign bus.r0_addr_o   = rsp_addr_q[0];
  assign bus.r0_data_o   = rsp_data_q[0];
  assign bus.r1_busy_o   = busy[1];
  assign bus.r1_ack_o    = ack[1];
  assign bus.r1_err_o    = ack[1] & err_q;
  assign bus.r1_addr_o   = rsp_addr_q[1];
  assign bus.r1_data_o   = rsp_data_q[1];
  assign bus.dma_addr_o  = dma_addr_q;
  assign bus.dma_valid_o = dma_valid_q;
  assign bus.timeout_o   = to_q;
  assign bus.addr_err_o  = aerr_q;

endmodule
